// File: rtl/tbcm_stream_arbiter.sv
// Packet-granular round-robin arbiter merging REQUESTS valid/ready streams into one.
// Optional output register stage: define TBCM_STREAM_ARBITER_OUTPUT_REG_EN.
module tbcm_stream_arbiter #(
  parameter int unsigned         REQUESTS      = 2,
  parameter int unsigned         DATA_WIDTH    = 32,
  parameter logic [REQUESTS-1:0] INITIAL_GRANT = REQUESTS'(1),
  localparam int unsigned        ID_W          = (REQUESTS > 2) ? $clog2(REQUESTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [REQUESTS-1:0]            i_valid,
  output logic [REQUESTS-1:0]            o_ready,
  input  logic [REQUESTS*DATA_WIDTH-1:0] i_data,
  input  logic [REQUESTS-1:0]            i_last,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic                           o_last,
  output logic [ID_W-1:0]                o_id,
  output logic [REQUESTS-1:0]            o_grant
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state, next_state;
  logic [REQUESTS-1:0]   ptr, next_ptr;
  logic [REQUESTS-1:0]   lock_grant, next_lock;
  logic [REQUESTS-1:0]   win, above, req_hi;
  logic [REQUESTS-1:0]   grant;
  logic [DATA_WIDTH-1:0] data_arr [REQUESTS];
  logic                  sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ID_W-1:0]       sel_id;
  logic                  accept, take;

  for (genvar g = 0; g < REQUESTS; g++) begin : g_unpack
    assign data_arr[g] = i_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: lowest requester strictly above the pointer, else lowest overall.
  always_comb begin
    above  = ~(ptr | (ptr - REQUESTS'(1)));
    req_hi = i_valid & above;
    if (|req_hi) win = req_hi & (~req_hi + REQUESTS'(1));
    else         win = i_valid & (~i_valid + REQUESTS'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= INITIAL_GRANT;
      lock_grant <= '0;
    end else begin
      state      <= next_state;
      ptr        <= next_ptr;
      lock_grant <= next_lock;
    end
  end

  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    next_lock  = lock_grant;
    case (state)
      IDLE: begin
        if (|win) begin
          next_ptr = win;
          if (!(take && sel_last)) begin
            next_state = LOCKED;
            next_lock  = win;
          end
        end
      end
      LOCKED: begin
        if (take && sel_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Grant is forced to zero while reset is held so every output reads zero.
  always_comb begin
    if (!rst_n)              grant = '0;
    else if (state == LOCKED) grant = lock_grant;
    else                     grant = win;
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    sel_id   = '0;
    for (int k = 0; k < REQUESTS; k++) begin
      if (grant[k]) begin
        sel_data = sel_data | data_arr[k];
        sel_last = sel_last | i_last[k];
        sel_id   = sel_id | ID_W'(k);
      end
    end
    sel_valid = |(i_valid & grant);
  end

`ifdef TBCM_STREAM_ARBITER_OUTPUT_REG_EN
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  last_p1;
  logic [ID_W-1:0]       id_p1;

  assign accept = !vld_p1 || i_ready;

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      id_p1   <= '0;
    end else if (accept) begin
      vld_p1  <= sel_valid;
      data_p1 <= sel_data;
      last_p1 <= sel_last;
      id_p1   <= sel_id;
    end
  end

  assign o_valid = vld_p1;
  assign o_data  = data_p1;
  assign o_last  = last_p1;
  assign o_id    = id_p1;
`else
  assign accept  = i_ready;
  assign o_valid = sel_valid;
  assign o_data  = sel_data;
  assign o_last  = sel_last;
  assign o_id    = sel_id;
`endif

  assign take    = sel_valid && accept;
  assign o_ready = grant & {REQUESTS{accept}};
  assign o_grant = grant;

endmodule

// File: tb/tb_tbcm_stream_arbiter.sv
// Bench for tbcm_stream_arbiter (REQUESTS=4, DATA_WIDTH=8): directed scenarios plus
// randomized traffic against a packet-level round-robin reference model.
module tb_tbcm_stream_arbiter;

`ifdef TBCM_STREAM_ARBITER_OUTPUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_valid, o_ready, i_last, o_grant;
  logic [31:0] i_data;
  logic        o_valid, i_ready, o_last;
  logic [7:0]  o_data;
  logic [1:0]  o_id;

  int vectors = 0;
  int miscompares = 0;

  tbcm_stream_arbiter #(
    .REQUESTS(4), .DATA_WIDTH(8), .INITIAL_GRANT(4'b0001)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_last(o_last), .o_id(o_id), .o_grant(o_grant)
  );

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_hold
    assert property (@(posedge clk) disable iff (!rst_n)
      (i_valid[k] && !o_ready[k]) |=> (i_valid[k] && $stable(i_last[k]) && $stable(i_data[k*8 +: 8])));
  end

  // Upstream sources
  bit         src_on [4];
  int         src_len [4];
  int         cur_len [4];
  int         beat [4];
  logic [7:0] seq [4];
  int         src_pct = 100;
  bit         rand_ready = 0;
  int         ready_pct = 100;

  // Reference model
  int         m_ptr;
  bit         m_locked;
  int         m_lock;
  logic       m_rv, m_rl;
  logic [7:0] m_rd;
  logic [1:0] m_rid;

  // Values seen on the last step
  logic       obs_valid, obs_xfer;
  logic [7:0] obs_data;
  logic [1:0] obs_id;
  logic [3:0] obs_grant, obs_ready;

  task automatic drive_src(int k);
    if (!i_valid[k] && src_on[k] && $urandom_range(99) < src_pct) begin
      cur_len[k] = (src_len[k] > 0) ? src_len[k] : int'($urandom_range(4, 1));
      beat[k] = 0;
      i_valid[k] = 1'b1;
      i_data[k*8 +: 8] = seq[k];
      i_last[k] = (cur_len[k] == 1);
    end
  endtask

  task automatic advance_src(int k);
    seq[k] = seq[k] + 8'd1;
    beat[k]++;
    if (beat[k] == cur_len[k]) begin
      i_valid[k] = 1'b0;
      i_last[k] = 1'b0;
    end else begin
      i_data[k*8 +: 8] = seq[k];
      i_last[k] = (beat[k] == cur_len[k] - 1);
    end
  endtask

  task automatic kick();
    for (int k = 0; k < 4; k++) drive_src(k);
  endtask

  task automatic clear_all();
    i_valid = '0; i_last = '0; i_data = '0; i_ready = 1'b1;
    rand_ready = 0; src_pct = 100;
    for (int k = 0; k < 4; k++) begin
      src_on[k] = 0; src_len[k] = 1; cur_len[k] = 0; beat[k] = 0; seq[k] = 8'(k * 16);
    end
    m_ptr = 0; m_locked = 0; m_lock = 0;
    m_rv = 0; m_rl = 0; m_rd = '0; m_rid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic int model_grant();
    if (!rst_n) return -1;
    if (m_locked) return m_lock;
    for (int j = 1; j <= 4; j++) begin
      int c = (m_ptr + j) % 4;
      if (i_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle: compare all outputs against the model, then advance model and sources.
  task automatic step();
    int g;
    bit acc, sv, hs, sl;
    logic [7:0] sd, ed;
    logic [1:0] sid, eid;
    logic [3:0] eg, er;
    logic ev, el;
    logic [19:0] exp_v, act_v;
    @(negedge clk);
    g   = model_grant();
    sv  = (g >= 0) && i_valid[g];
    sd  = (g >= 0) ? 8'(i_data >> (8 * g)) : 8'h00;
    sl  = (g >= 0) ? i_last[g] : 1'b0;
    sid = (g >= 0) ? 2'(g) : 2'd0;
`ifdef TBCM_STREAM_ARBITER_OUTPUT_REG_EN
    acc = !m_rv || i_ready;
    ev = m_rv; ed = m_rd; el = m_rl; eid = m_rid;
`else
    acc = i_ready;
    ev = sv; ed = sd; el = sl; eid = sid;
`endif
    eg = (g >= 0) ? 4'(1 << g) : 4'h0;
    er = acc ? eg : 4'h0;
    exp_v = {ev, eg, er, ed, el, eid};
    act_v = {o_valid, o_grant, o_ready, o_data, o_last, o_id};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL cycle t=%0t got v=%b g=%b r=%b d=%h l=%b id=%0d want v=%b g=%b r=%b d=%h l=%b id=%0d",
               $time, o_valid, o_grant, o_ready, o_data, o_last, o_id, ev, eg, er, ed, el, eid);
    end
    obs_valid = o_valid; obs_data = o_data; obs_id = o_id;
    obs_grant = o_grant; obs_ready = o_ready; obs_xfer = o_valid && i_ready;
    hs = sv && acc;
    @(posedge clk);
    if (rst_n) begin
      if (!m_locked && g >= 0) begin
        m_ptr = g;
        if (!(hs && sl)) begin m_locked = 1; m_lock = g; end
      end else if (m_locked && hs && sl) begin
        m_locked = 0;
      end
      if (acc) begin m_rv = sv; m_rd = sd; m_rl = sl; m_rid = sid; end
    end
    #1;
    if (hs) advance_src(g);
    kick();
    if (rand_ready) i_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic test_reset_and_rr();
    logic [1:0] ids [6];
    int exp_ids [5] = '{1, 2, 3, 0, 1};
    do_reset();
    #1;
    vectors++;
    if (o_valid !== 1'b0 || o_grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_state got v=%b g=%b want v=0 g=0000", o_valid, o_grant);
    end
    for (int k = 0; k < 4; k++) begin src_on[k] = 1; src_len[k] = 1; end
    kick();
    for (int s = 0; s < 5 + LAT; s++) begin step(); ids[s] = obs_id; end
    for (int s = 0; s < 5; s++) begin
      vectors++;
      if (ids[s + LAT] !== 2'(exp_ids[s])) begin
        miscompares++;
        $display("FAIL rr_order idx=%0d got=%0d want=%0d", s, ids[s + LAT], exp_ids[s]);
      end
    end
  endtask

  task automatic test_packet_lock();
    logic [7:0] dat [5];
    logic [1:0] idv [5];
    logic [3:0] rdy [5];
    logic [7:0] exp_d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
    do_reset();
    seq[2] = 8'hA0; seq[3] = 8'hB0;
    src_on[2] = 1; src_len[2] = 3; src_len[3] = 1;
    kick();
    step(); dat[0] = obs_data; idv[0] = obs_id; rdy[0] = obs_ready;
    src_on[3] = 1; kick();
    step(); dat[1] = obs_data; idv[1] = obs_id; rdy[1] = obs_ready;
    src_on[2] = 0;
    for (int s = 2; s < 4 + LAT; s++) begin
      step(); dat[s] = obs_data; idv[s] = obs_id; rdy[s] = obs_ready;
    end
    for (int s = 0; s < 4; s++) begin
      vectors++;
      if (dat[s + LAT] !== exp_d[s]) begin
        miscompares++;
        $display("FAIL lock_data idx=%0d got=%h want=%h", s, dat[s + LAT], exp_d[s]);
      end
    end
    vectors++;
    if (idv[3 + LAT] !== 2'd3) begin
      miscompares++;
      $display("FAIL lock_next_id got=%0d want=3", idv[3 + LAT]);
    end
    for (int s = 1; s < 3; s++) begin
      vectors++;
      if (rdy[s][3] !== 1'b0) begin
        miscompares++;
        $display("FAIL lock_ready3 cycle=%0d got=%b want=0", s, rdy[s][3]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    seq[0] = 8'h10; src_on[0] = 1; src_len[0] = 4;
    kick();
    src_on[0] = 0;
    step();
    i_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
`ifndef TBCM_STREAM_ARBITER_OUTPUT_REG_EN
      vectors++;
      if (obs_data !== 8'h11 || obs_grant !== 4'b0001 || obs_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold cycle=%0d got d=%h g=%b v=%b want d=11 g=0001 v=1",
                 s, obs_data, obs_grant, obs_valid);
      end
`endif
    end
    i_ready = 1'b1;
    step();
`ifndef TBCM_STREAM_ARBITER_OUTPUT_REG_EN
    vectors++;
    if (obs_xfer !== 1'b1 || obs_data !== 8'h11) begin
      miscompares++;
      $display("FAIL bp_release got xfer=%b d=%h want xfer=1 d=11", obs_xfer, obs_data);
    end
`endif
    for (int s = 0; s < 4; s++) step();
  endtask

  task automatic test_single_requester();
    int bad = 0;
    do_reset();
    src_on[0] = 1; src_len[0] = 2;
    kick();
    for (int s = 0; s < 8 + LAT; s++) begin
      step();
      if (s >= LAT && (obs_id !== 2'd0 || obs_xfer !== 1'b1)) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL single_req bad_beats got=%0d want=0", bad);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [1:0] last_id;
    do_reset();
    src_on[2] = 1; src_len[2] = 3;
    kick();
    step();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_valid, o_grant, o_ready, o_data, o_last, o_id} !== 20'h0) begin
      miscompares++;
      $display("FAIL mid_reset got v=%b g=%b r=%b d=%h l=%b id=%0d want all zero",
               o_valid, o_grant, o_ready, o_data, o_last, o_id);
    end
    clear_all();
    src_on[1] = 1; src_on[2] = 1; src_len[1] = 3; src_len[2] = 3;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    kick();
    for (int s = 0; s <= LAT; s++) step();
    last_id = obs_id;
    vectors++;
    if (last_id !== 2'd1) begin
      miscompares++;
      $display("FAIL restart_winner got=%0d want=1", last_id);
    end
    for (int s = 0; s < 8; s++) step();
  endtask

  task automatic test_ready_toggle();
    int n = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin src_on[k] = 1; src_len[k] = 1; end
    kick();
    for (int s = 0; s < 12; s++) begin
      i_ready = (s % 2 == 0);
      step();
      if (obs_xfer) begin
        vectors++;
        if (obs_id !== 2'((n + 1) % 4)) begin
          miscompares++;
          $display("FAIL toggle_order n=%0d got=%0d want=%0d", n, obs_id, (n + 1) % 4);
        end
        n++;
      end
    end
    vectors++;
    if (n != 6 - LAT) begin
      miscompares++;
      $display("FAIL toggle_count got=%0d want=%0d", n, 6 - LAT);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 4; k++) begin src_on[k] = 1; src_len[k] = 0; end
    src_pct = 50;
    rand_ready = 1; ready_pct = 70;
    kick();
    for (int s = 0; s < 600; s++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_all();
    test_reset_and_rr();
    test_packet_lock();
    test_backpressure();
    test_single_requester();
    test_reset_mid_packet();
    test_ready_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tbcm_stream_arbiter.md
Name: tbcm_stream_arbiter

Overview:
- Shares one valid/ready output stream between REQUESTS input streams at packet granularity.
- Round-robin selection: the winner holds the output until its last beat is accepted, then arbitration passes on.
- Sits in front of any shared single-port sink, such as a bus master port or a shared FIFO, in the tbcm library.
- The round-robin rule matches the library's round-robin arbiter: the search starts at the bit after the previous winner and wraps.

Parameters:
- REQUESTS, 2, number of input streams; legal values are 2 or more.
- DATA_WIDTH, 32, width of each stream's payload.
- INITIAL_GRANT, 1, one-hot round-robin pointer value at reset; must be one-hot, so bit 0 is the previous winner and input 1 has first priority.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  REQUESTS  per-input valid.
- o_ready  output  REQUESTS  per-input ready.
- i_data  input  REQUESTS*DATA_WIDTH  packed payloads; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_last  input  REQUESTS  per-input end-of-packet flag.
- o_valid  output  1  output valid.
- i_ready  input  1  output ready from the sink.
- o_data  output  DATA_WIDTH  selected payload.
- o_last  output  1  selected end-of-packet flag.
- o_id  output  max(1,$clog2(REQUESTS))  binary index of the granted input.
- o_grant  output  REQUESTS  one-hot grant; all zeros when idle.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - state = IDLE.
  - Round-robin pointer = INITIAL_GRANT.
  - o_valid = 0, o_grant = 0, o_ready = 0, o_id = 0, o_last = 0, o_data = 0.
- Transfer: a beat moves when o_valid && i_ready.
- Upstream rule: after asserting i_valid[k], input k holds valid, data and last stable until o_ready[k] is seen. The bench checks this as an assertion.
- State IDLE:
  - If no input is valid: o_grant = 0 and o_valid = 0.
  - Otherwise the winner is the first valid input found scanning from pointer+1 upward, wrapping modulo REQUESTS.
  - Grant is combinational in the same cycle, so entry latency is 0 cycles.
  - Pointer <= winner at the clock edge.
  - If the beat transfers with last=1: stay in IDLE.
  - Otherwise go to LOCKED with the locked grant = winner.
- State LOCKED:
  - o_grant = locked grant, regardless of other inputs' valid.
  - Go back to IDLE when a beat transfers with last=1.
  - Stays LOCKED while i_ready=0, which guarantees output stability under backpressure.
- Datapath (both states):
  - o_valid = |(i_valid & o_grant).
  - o_data, o_last and o_id come from the granted input; when o_grant = 0 they drive all zeros.
  - o_ready = o_grant & {REQUESTS{i_ready}}.
  - Ungranted inputs always see ready = 0.
- Back-to-back packets: after the last beat, the next cycle re-arbitrates in IDLE. No bubble is inserted beyond the one clock edge.
- Single requester: re-wins every packet; the pointer stays on it.
- Inputs that raise valid mid-packet wait until the current packet's last beat.
- Reset asserted mid-packet: immediate return to the reset values. The partial packet is abandoned; the upstream logic is responsible for recovery.
- No combinational path from i_ready to o_valid.

Optional Feature:
- Macro: TBCM_STREAM_ARBITER_OUTPUT_REG_EN.
- Defined:
  - o_valid, o_data, o_last and o_id are driven from an output register stage.
  - Register loads when it is empty or i_ready=1: input-side accept = !reg_valid || i_ready.
  - Adds exactly 1 cycle of latency; full throughput of 1 beat per cycle is preserved.
  - o_grant and o_ready stay arbitration-side.
  - The register resets to valid=0 and data=0.
- Undefined: the purely combinational output path described in Behaviour.

Test Plan (REQUESTS=4, DATA_WIDTH=8, INITIAL_GRANT=4'b0001, macro undefined unless stated):
1. Reset state -> after rst_n release, o_valid=0, o_grant=0. Then i_valid=4'b1111, all single-beat (last=1), i_ready=1 -> o_id sequence 1,2,3,0,1 on consecutive cycles.
2. Packet locking -> input 2 sends 3 beats (0xA0,0xA1,0xA2 with last on 0xA2) while input 3 is valid from cycle 1 -> o_data=A0,A1,A2, then input 3's beat. o_ready[3]=0 throughout input 2's packet.
3. Backpressure -> i_ready held 0 for 5 cycles mid-packet -> o_grant, o_data and o_valid constant. The beat is accepted on the first cycle i_ready=1.
4. Single requester -> only input 0 valid, 4 packets of 2 beats -> o_id=0 for all 8 beats, no idle cycles between packets.
5. Reset mid-packet -> rst_n pulsed low after beat 1 of 3 -> all outputs zero immediately. After release, arbitration restarts from INITIAL_GRANT, so input 1 wins if valid.
6. TBCM_STREAM_ARBITER_OUTPUT_REG_EN defined, scenario 1 repeated -> same o_id order shifted by 1 cycle. i_ready toggling 1,0,1,0 loses no beats and duplicates none.
